// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK channels clocked by a shared prescaler strobe, with
// 2-stage input synchronizers, a parallel load, and per-channel change pulses.
module jk_reg_bank #(
  parameter int                 WIDTH     = 4,
  parameter int                 DIV       = 100000000,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             tick,
  output logic [WIDTH-1:0] chg
);

  localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  logic [WIDTH-1:0] j_s1_q, j_s1_d, j_s2_q, j_s2_d;
  logic [WIDTH-1:0] k_s1_q, k_s1_d, k_s2_q, k_s2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             tick_q, tick_d;
  logic             upd;

  always_comb begin
    j_s1_d = J;
    j_s2_d = j_s1_q;
    k_s1_d = K;
    k_s2_d = k_s1_q;

    // A load both restarts the prescaler and suppresses the strobe on its edge.
    upd   = en && !load && (cnt_q == CNT_MAX);

    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = upd ? '0 : cnt_q + 1'b1;
    end

    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (upd) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j_s2_q[i], k_s2_q[i]})
          2'b01:   q_d[i] = 1'b0;
          2'b10:   q_d[i] = 1'b1;
          2'b11:   q_d[i] = ~q_q[i];
          default: q_d[i] = q_q[i];
        endcase
      end
    end

    chg_d  = q_d ^ q_q;
    tick_d = upd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_s1_q <= '0;
      j_s2_q <= '0;
      k_s1_q <= '0;
      k_s2_q <= '0;
      cnt_q  <= '0;
      q_q    <= RESET_VAL;
      chg_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      j_s1_q <= j_s1_d;
      j_s2_q <= j_s2_d;
      k_s1_q <= k_s1_d;
      k_s2_q <= k_s2_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      chg_q  <= chg_d;
      tick_q <= tick_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;
  assign tick  = tick_q;
  assign chg   = chg_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=4, DIV=4): one table row per clock edge,
// plus hand-written load-on-update and asynchronous reset sequences.
module tb_jk_reg_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] J;
  logic [3:0] K;
  logic       load;
  logic [3:0] load_data;
  logic [3:0] Q;
  logic [3:0] Q_bar;
  logic       tick;
  logic [3:0] chg;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic       en;
    logic       load;
    logic [3:0] ld;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic       t;
    logic [3:0] c;
  } vec_t;

  vec_t tbl[$];

  jk_reg_bank #(
    .WIDTH(4),
    .DIV(4),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .J(J),
    .K(K),
    .load(load),
    .load_data(load_data),
    .Q(Q),
    .Q_bar(Q_bar),
    .tick(tick),
    .chg(chg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eq, input logic et,
                            input logic [3:0] ec);
    chk({tag, " Q"},     Q,            eq);
    chk({tag, " Q_bar"}, Q_bar,        ~eq);
    chk({tag, " tick"},  {3'b000, tick}, {3'b000, et});
    chk({tag, " chg"},   chg,          ec);
  endtask

  // Drive one row's inputs, let one rising edge pass, check shortly after it.
  task automatic run_row(input vec_t v, input string tag);
    en        = v.en;
    load      = v.load;
    load_data = v.ld;
    J         = v.j;
    K         = v.k;
    @(posedge clk);
    #1;
    check_outs(tag, v.q, v.t, v.c);
  endtask

  function automatic vec_t mk(input logic e, input logic l, input logic [3:0] ld,
                              input logic [3:0] j, input logic [3:0] k,
                              input logic [3:0] q, input logic t, input logic [3:0] c);
    vec_t v;
    v.en = e; v.load = l; v.ld = ld; v.j = j; v.k = k; v.q = q; v.t = t; v.c = c;
    return v;
  endfunction

  task automatic add(input int n, input vec_t v);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; load_data = 4'h0; J = 4'hF; K = 4'hF;

    // ---- table: reset release, set, toggle, clear, en freeze ----
    add(3, mk(1, 0, 4'h0, 4'b0101, 4'h0, 4'h0, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'b0101, 4'h0, 4'h5, 1, 4'h5));
    add(3, mk(1, 0, 4'h0, 4'b0101, 4'h0, 4'h5, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'b0101, 4'h0, 4'h5, 1, 4'h0));
    add(3, mk(1, 0, 4'h0, 4'hF,    4'hF, 4'h5, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'hF,    4'hF, 4'hA, 1, 4'hF));
    add(3, mk(1, 0, 4'h0, 4'hF,    4'hF, 4'hA, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'hF,    4'hF, 4'h5, 1, 4'hF));
    add(3, mk(1, 0, 4'h0, 4'hF,    4'hF, 4'h5, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'hF,    4'hF, 4'hA, 1, 4'hF));
    add(1, mk(1, 1, 4'hF, 4'h0,    4'h3, 4'hF, 0, 4'h5));
    add(3, mk(1, 0, 4'h0, 4'h0,    4'h3, 4'hF, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'h0,    4'h3, 4'hC, 1, 4'h3));
    add(2, mk(1, 0, 4'h0, 4'h0,    4'h3, 4'hC, 0, 4'h0));
    add(10, mk(0, 0, 4'h0, 4'h0,   4'h3, 4'hC, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'h0,    4'h3, 4'hC, 0, 4'h0));
    add(1, mk(1, 0, 4'h0, 4'h0,    4'h3, 4'hC, 1, 4'h0));

    // reset held with J=K=F and the clock running: everything stays cleared
    #1;
    check_outs("async_rst_t0", 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++)
      run_row(mk(1, 0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 4'h0), $sformatf("in_rst%0d", i));

    rst = 1'b1;
    for (int i = 0; i < tbl.size(); i++)
      run_row(tbl[i], $sformatf("row%0d", i));

    // ---- load landing on the update edge: no tick, counter restarts ----
    for (int i = 0; i < 3; i++)
      run_row(mk(1, 0, 4'h0, 4'h0, 4'h3, 4'hC, 0, 4'h0), $sformatf("pre_ld%0d", i));
    run_row(mk(1, 1, 4'h9, 4'h0, 4'h3, 4'h9, 0, 4'h5), "ld_on_upd");
    for (int i = 0; i < 3; i++)
      run_row(mk(1, 0, 4'h0, 4'h0, 4'h3, 4'h9, 0, 4'h0), $sformatf("post_ld%0d", i));
    run_row(mk(1, 0, 4'h0, 4'h0, 4'h3, 4'h8, 1, 4'h1), "tick_after_ld");

    // ---- load of the current value is not a change ----
    run_row(mk(1, 1, 4'h8, 4'h0, 4'h3, 4'h8, 0, 4'h0), "ld_same");
    run_row(mk(1, 1, 4'hA, 4'h0, 4'h0, 4'hA, 0, 4'h2), "ld_A");
    run_row(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hA, 0, 4'h0), "mid_cnt1");
    run_row(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'hA, 0, 4'h0), "mid_cnt2");

    // ---- asynchronous reset mid-count, before any edge ----
    rst = 1'b0;
    #1;
    check_outs("rst_async", 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 2; i++)
      run_row(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0), $sformatf("rst_hold%0d", i));
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      run_row(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0), $sformatf("rel%0d", i));
    run_row(mk(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0), "rel_tick");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
